// File: rtl/chunked_rca_adder_pkg.sv
// Shared types and helpers for the chunked ripple-carry adder/subtractor.
package chunked_rca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of the chunk counter: max(1, clog2(n)) so a single-chunk adder still has a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_rca_adder_if.sv
// Operand/result handshake bundle between producers, the adder and consumers.
interface chunked_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_rca_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder equations.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_rca_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock, carry held in a register.
module chunked_rca_adder
  import chunked_rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  chunked_rca_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_rca_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_msb;

  // Single shared slice; the counter selects which chunk of the operands it sees.
  assign a_c = a_q[int'(cnt)*CHUNK +: CHUNK];
  assign b_c = b_q[int'(cnt)*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_c),
    .b     (b_c),
    .cin   (carry),
    .sum   (s_c),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            // Subtraction becomes a + ~b + ~cin, i.e. a - b - borrow.
            a_q        <= bus.a;
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub ^ bus.cin;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(cnt)*CHUNK +: CHUNK] <= s_c;
          carry <= c_out;
          if (cnt == LAST) begin
            cout_q      <= c_out;
            ovf_q       <= c_msb ^ c_out;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_rca_adder.sv
// Scoreboard bench for chunked_rca_adder across four WIDTH/CHUNK configurations.
module tb_chunked_rca_adder;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } obs_t;

  typedef struct {
    int          cfg;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // cfg 0: 16/4, cfg 1: 16/1, cfg 2: 16/16, cfg 3: 32/8
  int w_of [4] = '{16, 16, 16, 32};
  int nc_of[4] = '{4, 16, 1, 4};

  always #5 clk = ~clk;

  chunked_rca_adder_if #(.WIDTH(16)) if0 ();
  chunked_rca_adder_if #(.WIDTH(16)) if1 ();
  chunked_rca_adder_if #(.WIDTH(16)) if2 ();
  chunked_rca_adder_if #(.WIDTH(32)) if3 ();

  chunked_rca_adder #(.WIDTH(16), .CHUNK(4))  u0 (.clk(clk), .rst(rst), .bus(if0));
  chunked_rca_adder #(.WIDTH(16), .CHUNK(1))  u1 (.clk(clk), .rst(rst), .bus(if1));
  chunked_rca_adder #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .rst(rst), .bus(if2));
  chunked_rca_adder #(.WIDTH(32), .CHUNK(8))  u3 (.clk(clk), .rst(rst), .bus(if3));

  function automatic obs_t read_out(int cfg);
    obs_t o;
    case (cfg)
      0:       o = '{if0.in_ready, if0.out_valid, 32'(if0.sum), if0.cout, if0.ovf};
      1:       o = '{if1.in_ready, if1.out_valid, 32'(if1.sum), if1.cout, if1.ovf};
      2:       o = '{if2.in_ready, if2.out_valid, 32'(if2.sum), if2.cout, if2.ovf};
      default: o = '{if3.in_ready, if3.out_valid, if3.sum, if3.cout, if3.ovf};
    endcase
    return o;
  endfunction

  task automatic drive(int cfg, logic iv, logic [31:0] a, logic [31:0] b,
                       logic cin, logic sub, logic ordy);
    case (cfg)
      0: begin if0.in_valid = iv; if0.a = a[15:0]; if0.b = b[15:0];
               if0.cin = cin; if0.sub = sub; if0.out_ready = ordy; end
      1: begin if1.in_valid = iv; if1.a = a[15:0]; if1.b = b[15:0];
               if1.cin = cin; if1.sub = sub; if1.out_ready = ordy; end
      2: begin if2.in_valid = iv; if2.a = a[15:0]; if2.b = b[15:0];
               if2.cin = cin; if2.sub = sub; if2.out_ready = ordy; end
      default: begin if3.in_valid = iv; if3.a = a; if3.b = b;
               if3.cin = cin; if3.sub = sub; if3.out_ready = ordy; end
    endcase
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result sign rule.
  function automatic exp_t model(int cfg, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    exp_t        r;
    int          w = w_of[cfg];
    int          m = w - 1;
    logic [31:0] mask;
    logic [31:0] x;
    logic [31:0] y;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    x      = a & mask;
    y      = (sub ? ~b : b) & mask;
    full   = {1'b0, x} + {1'b0, y} + 33'(sub ^ cin);
    r.cfg  = cfg;
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (x[m] == y[m]) && (r.sum[m] != x[m]);
    return r;
  endfunction

  task automatic start_op(int cfg, logic [31:0] a, logic [31:0] b, logic cin, logic sub, exp_t e);
    obs_t o;
    int   n = 0;
    @(negedge clk);
    o = read_out(cfg);
    while (!o.ir && n < 50) begin
      @(negedge clk);
      n++;
      o = read_out(cfg);
    end
    if (!o.ir) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout cfg%0d: in_ready=%0b after %0d cycles, required 1", cfg, o.ir, n);
    end
    drive(cfg, 1'b1, a, b, cin, sub, 1'b0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Scrambled operands after acceptance must not disturb the result.
    drive(cfg, 1'b0, ~a, ~b, ~cin, ~sub, 1'b0);
  endtask

  task automatic finish_op(int cfg, int hold);
    obs_t o;
    exp_t e;
    int   n = 0;
    o = read_out(cfg);
    while (!o.ov && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      o = read_out(cfg);
    end
    checks++;
    if (n != nc_of[cfg]) begin
      errors++;
      $display("FAIL latency cfg%0d: got %0d cycles, required %0d", cfg, n, nc_of[cfg]);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty cfg%0d: result with no expected entry", cfg);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (o.sum !== e.sum) begin
      errors++;
      $display("FAIL sum cfg%0d: got %h, required %h", cfg, o.sum, e.sum);
    end
    checks++;
    if (o.cout !== e.cout) begin
      errors++;
      $display("FAIL cout cfg%0d: got %0b, required %0b", cfg, o.cout, e.cout);
    end
    checks++;
    if (o.ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf cfg%0d: got %0b, required %0b", cfg, o.ovf, e.ovf);
    end
    for (int i = 0; i < hold; i++) begin
      drive(cfg, 1'b1, 32'h0000_AAAA, 32'h0000_5555, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      o = read_out(cfg);
      checks++;
      if ({o.ov, o.ir, o.sum, o.cout, o.ovf} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL hold cfg%0d cycle %0d: ov=%0b ir=%0b sum=%h cout=%0b ovf=%0b, required ov=1 ir=0 sum=%h cout=%0b ovf=%0b",
                 cfg, i, o.ov, o.ir, o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
      end
    end
    drive(cfg, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(cfg, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    o = read_out(cfg);
    checks++;
    if (o.ov !== 1'b0 || o.ir !== 1'b1) begin
      errors++;
      $display("FAIL release cfg%0d: out_valid=%0b in_ready=%0b, required 0/1", cfg, o.ov, o.ir);
    end
  endtask

  task automatic run_op(int cfg, logic [31:0] a, logic [31:0] b, logic cin, logic sub, exp_t e);
    start_op(cfg, a, b, cin, sub, e);
    finish_op(cfg, 0);
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) drive(c, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      o = read_out(c);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_state cfg%0d: ir=%0b ov=%0b sum=%h cout=%0b ovf=%0b, required all 0",
                 c, o.ir, o.ov, o.sum, o.cout, o.ovf);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o = read_out(0);
    checks++;
    if (o.ir !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: in_ready=%0b, required 1", o.ir);
    end
  endtask

  task automatic test_add();
    run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, '{0, 32'h5555, 1'b0, 1'b0});
    run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, '{0, 32'h0000, 1'b1, 1'b0});
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, '{0, 32'h8000, 1'b0, 1'b1});
    run_op(0, 32'h8000, 32'hFFFF, 1'b0, 1'b0, '{0, 32'h7FFF, 1'b1, 1'b1});
    run_op(0, 32'h00FE, 32'h0001, 1'b1, 1'b0, '{0, 32'h0100, 1'b0, 1'b0});
  endtask

  task automatic test_sub();
    run_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, '{0, 32'hFFFE, 1'b0, 1'b0});
    run_op(0, 32'h0007, 32'h0005, 1'b1, 1'b1, '{0, 32'h0001, 1'b1, 1'b0});
    run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, '{0, 32'h7FFF, 1'b1, 1'b1});
  endtask

  task automatic test_backpressure();
    start_op(0, 32'h1111, 32'h2222, 1'b1, 1'b0, '{0, 32'h3334, 1'b0, 1'b0});
    finish_op(0, 10);
    run_op(0, 32'h0100, 32'h0001, 1'b0, 1'b1, '{0, 32'h00FF, 1'b1, 1'b0});
  endtask

  task automatic test_reset_abort();
    obs_t o;
    start_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, '{0, 32'h0000, 1'b1, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 o = read_out(0);
    checks++;
    if (o.ov !== 1'b0 || o.sum !== 32'h0 || o.ir !== 1'b0) begin
      errors++;
      $display("FAIL abort cfg0: out_valid=%0b sum=%h in_ready=%0b, required 0/0000/0", o.ov, o.sum, o.ir);
    end
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'h00FF, 32'h0001, 1'b0, 1'b0, '{0, 32'h0100, 1'b0, 1'b0});
  endtask

  task automatic test_configs();
    logic [31:0] ones;
    logic [31:0] maxp;
    for (int c = 1; c < 4; c++) begin
      ones = (w_of[c] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      maxp = ones >> 1;
      run_op(c, 32'h1234, 32'h4321, 1'b0, 1'b0, model(c, 32'h1234, 32'h4321, 1'b0, 1'b0));
      run_op(c, ones, 32'h1, 1'b0, 1'b0, model(c, ones, 32'h1, 1'b0, 1'b0));
      run_op(c, maxp, 32'h1, 1'b0, 1'b0, model(c, maxp, 32'h1, 1'b0, 1'b0));
      run_op(c, maxp + 32'h1, ones, 1'b0, 1'b0, model(c, maxp + 32'h1, ones, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      run_op(i % 4, a, b, cin, sub, model(i % 4, a, b, cin, sub));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_configs();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_rca_adder.md
Name: chunked_rca_adder

Overview:
Parametrised multi-cycle ripple-carry adder/subtractor and the sequential successor to our combinational 4-bit ripple-carry adder. It accepts one WIDTH-bit operand pair per transaction and adds CHUNK bits per clock, carrying between chunks in a register. It supports add and subtract, carry/borrow-in, carry-out and signed overflow. Results are returned through valid/ready handshakes. It sits between operand producers and arithmetic consumers where area matters more than throughput.

Parameters:
WIDTH, 16, operand and result width; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (derived, localparam), WIDTH/CHUNK, cycles per operation.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair offered
in_ready  out  1  block can accept operands
a  in  WIDTH  augend / minuend
b  in  WIDTH  addend / subtrahend
cin  in  1  carry-in (add) or borrow-in (sub)
sub  in  1  0 = a+b+cin; 1 = a-b-cin
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result modulo 2^WIDTH
cout  out  1  raw carry out of MSB (in sub mode, 1 = no borrow)
ovf  out  1  signed (two's-complement) overflow

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- While rst is high:
  - state = IDLE, chunk counter = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 0.
- State machine (states in the package): IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready, capture a and b_eff = sub ? ~b : b.
  - Capture carry register = sub ? ~cin : cin, so subtraction computes a + ~b + ~cin = a - b - cin.
  - Then clear the counter and go to RUN.
- RUN:
  - in_ready = 0.
  - Chunk k = counter. Add a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry.
  - Write the chunk result into sum[k*CHUNK +: CHUNK] and its carry-out into the carry register.
  - When k = NCHUNK-1:
    - cout = carry out of the MSB.
    - ovf = (carry into the MSB) XOR (carry out of the MSB).
    - Go to DONE and assert out_valid.
  - Otherwise increment k.
- DONE:
  - out_valid = 1. sum, cout and ovf are held stable until out_valid & out_ready.
  - On that handshake go to IDLE; out_valid drops on the next edge.
  - in_ready = 0 in DONE; there is no same-cycle bypass into IDLE.
- Latency and throughput:
  - out_valid rises NCHUNK cycles after the accepting edge.
  - Minimum initiation interval is NCHUNK+2 cycles.
  - NCHUNK = 1 degenerates to a 1-cycle registered adder.
- sum is valid only while out_valid = 1. During RUN it holds partially updated chunks.
- in_valid and its operands are ignored outside IDLE. Operand changes after acceptance have no effect.
- The carry chain wraps at the MSB with no modulo correction: sum = (a ± b ± cin) mod 2^WIDTH.
- Reset asserted mid-RUN or mid-DONE aborts the operation and produces no output. The first operation after reset release is unaffected.
- The counter is max(1, $clog2(NCHUNK)) bits wide and never exceeds NCHUNK-1.

Decomposition:
- Package chunked_rca_pkg:
  - State enum type (IDLE, RUN, DONE).
  - Helper function for the counter width.
- One sub-module, rca_chunk: a combinational CHUNK-bit ripple-carry adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (the carry into its top bit).
  - Built from full-adder equations and instantiated once, with chunk inputs muxed by the counter.
- Parameter legality (WIDTH % CHUNK == 0) is checked at elaboration; an illegal combination stops with an error.

Test Plan:
- WIDTH=16, CHUNK=4. a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0, add -> sum=0x0000, cout=1, ovf=0 (carry ripples through every chunk boundary).
- a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.
- sub=1: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0; a=0x0007, b=0x0005, cin=1 -> sum=0x0001, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. sum, cout, ovf and out_valid stay constant, in_ready=0, and a concurrent in_valid is not accepted. Releasing out_ready returns the block to IDLE, and the next pair is accepted.
- Assert rst asynchronously (mid-cycle) after 2 chunks of a=0xFFFF+0x0001 -> out_valid=0, sum=0, in_ready=0 immediately. After release, 0x00FF+0x0001 yields 0x0100, cout=0.
- Repeat the first three scenarios with CHUNK=1, CHUNK=16 and WIDTH=32/CHUNK=8, checking latency = NCHUNK.
